// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - reservation station holding issued instructions until operands are ready
//
// Accepts decoded instructions from the issue queue. Each entry waits until both
// operands have been captured, either from the register file or from a CDB
// broadcast. The oldest ready entry is then dispatched to a single functional unit.
//
// Ports:
//   clk, reset (async, active-low)
//   i_write, i_in_op, i_in_vj/vk, i_in_qj/qk, i_in_rj/rk, i_in_dest : allocate interface
//   o_stall                                : back-pressure to the issue queue (combinational)
//   i_cdb_valid, i_cdb_tag, i_cdb_data     : common data bus snoop
//   i_fu_ready                             : functional unit accepts an op this edge
//   o_disp_valid, o_disp_op/vj/vk/dest     : registered dispatch bundle
//   o_count                                : occupied entries
//   o_err_overflow                         : sticky, write arrived while full
module reservation_station #(
    parameter int NUM_ENTRIES = 4,
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 3,
    parameter int OP_W        = 6,
    parameter int CNT_W       = $clog2(NUM_ENTRIES) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_write,
    input  logic [OP_W-1:0]   i_in_op,
    input  logic [DATA_W-1:0] i_in_vj,
    input  logic [DATA_W-1:0] i_in_vk,
    input  logic [TAG_W-1:0]  i_in_qj,
    input  logic [TAG_W-1:0]  i_in_qk,
    input  logic              i_in_rj,
    input  logic              i_in_rk,
    input  logic [TAG_W-1:0]  i_in_dest,
    output logic              o_stall,
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_data,
    input  logic              i_fu_ready,
    output logic              o_disp_valid,
    output logic [OP_W-1:0]   o_disp_op,
    output logic [DATA_W-1:0] o_disp_vj,
    output logic [DATA_W-1:0] o_disp_vk,
    output logic [TAG_W-1:0]  o_disp_dest,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_err_overflow
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int AGE_W = $clog2(NUM_ENTRIES);

    logic              r_valid [NUM_ENTRIES];
    logic [OP_W-1:0]   r_op    [NUM_ENTRIES];
    logic [DATA_W-1:0] r_vj    [NUM_ENTRIES];
    logic [DATA_W-1:0] r_vk    [NUM_ENTRIES];
    logic [TAG_W-1:0]  r_qj    [NUM_ENTRIES];
    logic [TAG_W-1:0]  r_qk    [NUM_ENTRIES];
    logic              r_rj    [NUM_ENTRIES];
    logic              r_rk    [NUM_ENTRIES];
    logic [TAG_W-1:0]  r_dest  [NUM_ENTRIES];
    logic [AGE_W-1:0]  r_age   [NUM_ENTRIES];
    logic [CNT_W-1:0]  r_count;

    logic              w_free_found;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_sel_found;
    logic [IDX_W-1:0]  w_sel_idx;
    logic [AGE_W-1:0]  w_sel_age;
    logic              w_do_alloc;
    logic              w_do_disp;
    logic              w_byp_j;
    logic              w_byp_k;

    // Free slot comes from the registered valid bits, so a slot freed by a
    // dispatch on this edge cannot be claimed by an allocate on the same edge.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    // Oldest ready entry: ages are unique among valid entries, so the largest wins.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sel_age   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (r_valid[i] && r_rj[i] && r_rk[i] && (!w_sel_found || (r_age[i] > w_sel_age))) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
                w_sel_age   = r_age[i];
            end
        end
    end

    assign w_do_alloc = i_write && w_free_found;
    assign w_do_disp  = i_fu_ready && w_sel_found;
    assign w_byp_j    = !i_in_rj && i_cdb_valid && (i_cdb_tag == i_in_qj);
    assign w_byp_k    = !i_in_rk && i_cdb_valid && (i_cdb_tag == i_in_qk);

    // Dispatch on the same edge is not credited: the issue queue may already
    // have a write in flight, so stall must leave room for it.
    assign o_stall = ({1'b0, r_count} + (CNT_W + 1)'(i_write)) >= (CNT_W + 1)'(NUM_ENTRIES);
    assign o_count = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_op[i]    <= '0;
                r_vj[i]    <= '0;
                r_vk[i]    <= '0;
                r_qj[i]    <= '0;
                r_qk[i]    <= '0;
                r_rj[i]    <= 1'b0;
                r_rk[i]    <= 1'b0;
                r_dest[i]  <= '0;
                r_age[i]   <= '0;
            end
            r_count        <= '0;
            o_disp_valid   <= 1'b0;
            o_disp_op      <= '0;
            o_disp_vj      <= '0;
            o_disp_vk      <= '0;
            o_disp_dest    <= '0;
            o_err_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (r_valid[i]) begin
                    if (w_do_disp && (w_sel_idx == IDX_W'(i))) begin
                        r_valid[i] <= 1'b0;
                    end else begin
                        r_age[i] <= r_age[i] + AGE_W'(w_do_alloc)
                                  - AGE_W'(w_do_disp && (r_age[i] > w_sel_age));
                        if (!r_rj[i] && i_cdb_valid && (i_cdb_tag == r_qj[i])) begin
                            r_vj[i] <= i_cdb_data;
                            r_rj[i] <= 1'b1;
                        end
                        if (!r_rk[i] && i_cdb_valid && (i_cdb_tag == r_qk[i])) begin
                            r_vk[i] <= i_cdb_data;
                            r_rk[i] <= 1'b1;
                        end
                    end
                end else if (w_do_alloc && (w_free_idx == IDX_W'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_op[i]    <= i_in_op;
                    r_vj[i]    <= w_byp_j ? i_cdb_data : i_in_vj;
                    r_vk[i]    <= w_byp_k ? i_cdb_data : i_in_vk;
                    r_qj[i]    <= i_in_qj;
                    r_qk[i]    <= i_in_qk;
                    r_rj[i]    <= i_in_rj || w_byp_j;
                    r_rk[i]    <= i_in_rk || w_byp_k;
                    r_dest[i]  <= i_in_dest;
                    r_age[i]   <= '0;
                end
            end

            r_count <= r_count + CNT_W'(w_do_alloc) - CNT_W'(w_do_disp);

            if (i_write && !w_free_found) begin
                o_err_overflow <= 1'b1;
            end

            o_disp_valid <= w_do_disp;
            if (w_do_disp) begin
                o_disp_op   <= r_op[w_sel_idx];
                o_disp_vj   <= r_vj[w_sel_idx];
                o_disp_vk   <= r_vk[w_sel_idx];
                o_disp_dest <= r_dest[w_sel_idx];
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed self-checking bench for reservation_station
module tb_reservation_station;

    logic        clk;
    logic        reset;
    logic        i_write;
    logic [5:0]  i_in_op;
    logic [31:0] i_in_vj;
    logic [31:0] i_in_vk;
    logic [2:0]  i_in_qj;
    logic [2:0]  i_in_qk;
    logic        i_in_rj;
    logic        i_in_rk;
    logic [2:0]  i_in_dest;
    logic        o_stall;
    logic        i_cdb_valid;
    logic [2:0]  i_cdb_tag;
    logic [31:0] i_cdb_data;
    logic        i_fu_ready;
    logic        o_disp_valid;
    logic [5:0]  o_disp_op;
    logic [31:0] o_disp_vj;
    logic [31:0] o_disp_vk;
    logic [2:0]  o_disp_dest;
    logic [2:0]  o_count;
    logic        o_err_overflow;

    int n_vec;
    int n_err;

    reservation_station dut (
        .clk            (clk),
        .reset          (reset),
        .i_write        (i_write),
        .i_in_op        (i_in_op),
        .i_in_vj        (i_in_vj),
        .i_in_vk        (i_in_vk),
        .i_in_qj        (i_in_qj),
        .i_in_qk        (i_in_qk),
        .i_in_rj        (i_in_rj),
        .i_in_rk        (i_in_rk),
        .i_in_dest      (i_in_dest),
        .o_stall        (o_stall),
        .i_cdb_valid    (i_cdb_valid),
        .i_cdb_tag      (i_cdb_tag),
        .i_cdb_data     (i_cdb_data),
        .i_fu_ready     (i_fu_ready),
        .o_disp_valid   (o_disp_valid),
        .o_disp_op      (o_disp_op),
        .o_disp_vj      (o_disp_vj),
        .o_disp_vk      (o_disp_vk),
        .o_disp_dest    (o_disp_dest),
        .o_count        (o_count),
        .o_err_overflow (o_err_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                      input logic rj, input logic [2:0] qj, input logic rk, input logic [2:0] qk,
                      input logic [2:0] dest);
        i_write   = 1'b1;
        i_in_op   = op;
        i_in_vj   = vj;
        i_in_vk   = vk;
        i_in_rj   = rj;
        i_in_qj   = qj;
        i_in_rk   = rk;
        i_in_qk   = qk;
        i_in_dest = dest;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset       = 1'b0;
        i_write     = 1'b0;
        i_in_op     = '0;
        i_in_vj     = '0;
        i_in_vk     = '0;
        i_in_qj     = '0;
        i_in_qk     = '0;
        i_in_rj     = 1'b0;
        i_in_rk     = 1'b0;
        i_in_dest   = '0;
        i_cdb_valid = 1'b0;
        i_cdb_tag   = '0;
        i_cdb_data  = '0;
        i_fu_ready  = 1'b1;

        // reset state
        tick();
        tick();
        chk("rst_disp_valid", o_disp_valid, 0);
        chk("rst_count", o_count, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_err", o_err_overflow, 0);
        reset = 1'b1;

        // 1: ready instruction, minimum latency
        wr(6'd5, 32'd10, 32'd20, 1'b1, 3'd0, 1'b1, 3'd0, 3'd2);
        tick();
        i_write = 1'b0;
        chk("t1_count_alloc", o_count, 1);
        chk("t1_no_disp_early", o_disp_valid, 0);
        tick();
        chk("t1_disp_valid", o_disp_valid, 1);
        chk("t1_disp_op", o_disp_op, 5);
        chk("t1_disp_vj", o_disp_vj, 10);
        chk("t1_disp_vk", o_disp_vk, 20);
        chk("t1_disp_dest", o_disp_dest, 2);
        chk("t1_count_empty", o_count, 0);
        tick();
        chk("t1_disp_drop", o_disp_valid, 0);
        chk("t1_disp_op_hold", o_disp_op, 5);

        // 2: wait for CDB wakeup of vj
        wr(6'd7, 32'd0, 32'd33, 1'b0, 3'd3, 1'b1, 3'd0, 3'd1);
        tick();
        i_write = 1'b0;
        tick();
        chk("t2_wait_1", o_disp_valid, 0);
        tick();
        chk("t2_wait_2", o_disp_valid, 0);
        i_cdb_valid = 1'b1;
        i_cdb_tag   = 3'd3;
        i_cdb_data  = 32'hAA;
        tick();
        i_cdb_valid = 1'b0;
        chk("t2_no_same_edge", o_disp_valid, 0);
        tick();
        chk("t2_disp_valid", o_disp_valid, 1);
        chk("t2_disp_vj", o_disp_vj, 32'hAA);
        chk("t2_disp_vk", o_disp_vk, 33);
        chk("t2_disp_op", o_disp_op, 7);

        // 3: bypass of vk from CDB during allocate
        wr(6'd9, 32'd4, 32'd0, 1'b1, 3'd0, 1'b0, 3'd4, 3'd3);
        i_cdb_valid = 1'b1;
        i_cdb_tag   = 3'd4;
        i_cdb_data  = 32'd7;
        tick();
        i_write     = 1'b0;
        i_cdb_valid = 1'b0;
        chk("t3_count", o_count, 1);
        tick();
        chk("t3_disp_valid", o_disp_valid, 1);
        chk("t3_disp_vk", o_disp_vk, 7);
        chk("t3_disp_vj", o_disp_vj, 4);
        chk("t3_disp_dest", o_disp_dest, 3);

        // 4: fill with fu_ready=0, then overflow
        i_fu_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            wr(6'(k + 1), 32'd1, 32'd2, 1'b1, 3'd0, 1'b1, 3'd0, 3'(k));
            #1;
            chk($sformatf("t4_stall_%0d", k), o_stall, (k >= 3) ? 1 : 0);
            tick();
            chk($sformatf("t4_err_%0d", k), o_err_overflow, (k == 4) ? 1 : 0);
        end
        i_write = 1'b0;
        #1;
        chk("t4_count_full", o_count, 4);
        chk("t4_stall_full", o_stall, 1);
        chk("t4_disp_none", o_disp_valid, 0);
        reset = 1'b0;
        #1;
        chk("t4_err_cleared", o_err_overflow, 0);
        chk("t4_count_cleared", o_count, 0);
        reset = 1'b1;

        // 5: age order across slot reuse; P sits in slot 0 and leaves first
        tick();
        wr(6'h11, 32'd1, 32'd1, 1'b1, 3'd0, 1'b1, 3'd0, 3'd0);
        tick();
        wr(6'h12, 32'd2, 32'd2, 1'b1, 3'd0, 1'b1, 3'd0, 3'd1);
        tick();
        wr(6'h13, 32'd3, 32'd3, 1'b1, 3'd0, 1'b1, 3'd0, 3'd2);
        tick();
        i_write    = 1'b0;
        i_fu_ready = 1'b1;
        tick();
        chk("t5_disp_p", o_disp_op, 6'h11);
        chk("t5_count_p", o_count, 2);
        wr(6'h14, 32'd4, 32'd4, 1'b1, 3'd0, 1'b1, 3'd0, 3'd3);
        tick();
        i_write = 1'b0;
        chk("t5_disp_a", o_disp_op, 6'h12);
        chk("t5_count_a", o_count, 2);
        tick();
        chk("t5_disp_b", o_disp_op, 6'h13);
        chk("t5_valid_b", o_disp_valid, 1);
        tick();
        chk("t5_disp_c", o_disp_op, 6'h14);
        chk("t5_count_c", o_count, 0);
        tick();
        chk("t5_idle", o_disp_valid, 0);

        // 6: reset with entries pending and a dispatch in flight
        wr(6'h21, 32'd5, 32'd6, 1'b1, 3'd0, 1'b1, 3'd0, 3'd5);
        tick();
        wr(6'h22, 32'd0, 32'd8, 1'b0, 3'd6, 1'b1, 3'd0, 3'd6);
        tick();
        i_write = 1'b0;
        chk("t6_pre_valid", o_disp_valid, 1);
        chk("t6_pre_count", o_count, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", o_disp_valid, 0);
        chk("t6_rst_op", o_disp_op, 0);
        chk("t6_rst_count", o_count, 0);
        chk("t6_rst_stall", o_stall, 0);
        #2;
        reset = 1'b1;
        i_cdb_valid = 1'b1;
        i_cdb_tag   = 3'd6;
        i_cdb_data  = 32'h55;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t6_post_%0d", k), o_disp_valid, 0);
        end
        i_cdb_valid = 1'b0;
        chk("t6_post_count", o_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
